pmem_resp_buffer: RTL and testbench

PMEM_RESP_BUFFER -- requirements
Module: pmem_resp_buffer

---
 rtl/pmem_sync_pkg.sv | 18 +
 rtl/sync_fifo.sv | 78 +++++++
 rtl/pmem_resp_buffer.sv | 128 ++++++++++++
 tb/tb_pmem_resp_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_sync_pkg.sv
// Shared types and constants for the physical-memory response buffer.
package pmem_sync_pkg;

  // Request tracking states: no request outstanding / waiting for pmem_resp
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } pmem_state_e;

  // Bit positions inside the sticky err vector
  localparam int ERR_OVF  = 0;
  localparam int ERR_SPUR = 1;

  // Default geometry: one 256-bit line, two buffered responses
  localparam int PMEM_DATA_WIDTH_DEF = 256;
  localparam int PMEM_DEPTH_DEF      = 2;

endpackage : pmem_sync_pkg

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding buffered read lines.
// Pointers wrap naturally because DEPTH is a power of two. Storage is not
// reset; only pointers and count are, so the contents are meaningless
// while count is zero.
module sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves the same cycle
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state: pointers and count, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Line storage, written at the tail slot
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule : sync_fifo

// File: rtl/pmem_resp_buffer.sv
// Physical-memory response buffer.
// Tracks one outstanding read/write request, buffers read lines in a small
// FIFO for a stallable consumer, pulses wr_done on write completion and keeps
// sticky overflow / spurious-response flags.
// Optional build macro PMEM_RESP_BYPASS_EN: a read line arriving while the
// buffer is empty and the consumer is not stalled is presented combinationally
// in the same cycle instead of being stored.
module pmem_resp_buffer
  import pmem_sync_pkg::*;
#(
  parameter int DATA_WIDTH = PMEM_DATA_WIDTH_DEF,
  parameter int DEPTH      = PMEM_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic                  pmem_resp,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  output logic                  busy,
  output logic                  req_allow,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  wr_done,
  output logic [1:0]            err
);

  localparam int CW = $clog2(DEPTH) + 1;

  pmem_state_e           state_q, state_d;
  logic                  wr_done_q, wr_done_d;
  logic [1:0]            err_q, err_d;

  logic                  rd_resp;
  logic                  wr_resp;
  logic                  spur_resp;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_valid;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  // Completion qualifiers: only a response in WAIT is a real completion
  assign rd_resp   = (state_q == WAIT) && pmem_resp && pmem_read;
  assign wr_resp   = (state_q == WAIT) && pmem_resp && pmem_write;
  assign spur_resp = (state_q == IDLE) && pmem_resp;

`ifdef PMEM_RESP_BYPASS_EN
  assign bypass = rd_resp && fifo_empty && !stall;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && !stall;
  assign push       = rd_resp && !bypass;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pmem_rdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Request tracking: enter WAIT on any request, leave on its completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pmem_read || pmem_write) state_d = WAIT;
      WAIT:    if (pmem_resp)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flags and the registered write-completion pulse
  always_comb begin
    err_d     = err_q;
    wr_done_d = wr_resp;
    if (push && fifo_full && !pop) begin
      err_d[ERR_OVF] = 1'b1;
    end
    if (spur_resp) begin
      err_d[ERR_SPUR] = 1'b1;
    end
  end

  // Control registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_done_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
    end
  end

  // Head data is forced to zero while nothing is presented so reset shows 0
  always_comb begin
    resp_rdata = '0;
    if (bypass) begin
      resp_rdata = pmem_rdata;
    end else if (fifo_valid) begin
      resp_rdata = fifo_rdata;
    end
  end

  assign busy       = (state_q == WAIT);
  assign req_allow  = !fifo_full;
  assign resp_valid = fifo_valid || bypass;
  assign wr_done    = wr_done_q;
  assign err        = err_q;

endmodule : pmem_resp_buffer

// File: tb/tb_pmem_resp_buffer.sv
// Bench for pmem_resp_buffer: directed scenarios followed by randomized
// request/response/stall traffic, all compared against a queue-based model.
module tb_pmem_resp_buffer;

  localparam int DW    = 256;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          pmem_read;
  logic          pmem_write;
  logic          pmem_resp;
  logic [DW-1:0] pmem_rdata;
  logic          busy;
  logic          req_allow;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          wr_done;
  logic [1:0]    err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  bit            m_wait;
  bit            m_wd;
  logic [1:0]    m_err;

  pmem_resp_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_resp  (pmem_resp),
    .pmem_rdata (pmem_rdata),
    .busy       (busy),
    .req_allow  (req_allow),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .wr_done    (wr_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bypass();
`ifdef PMEM_RESP_BYPASS_EN
    return m_wait && pmem_resp && pmem_read && (mq.size() == 0) && !stall;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs(input string pfx);
    bit            byp;
    bit            ev;
    logic [DW-1:0] ed;
    byp = model_bypass();
    ev  = (mq.size() != 0) || byp;
    ed  = '0;
    if (byp)               ed = pmem_rdata;
    else if (mq.size() != 0) ed = mq[0];
    chk({pfx, ".busy"},       DW'(busy),       DW'(m_wait));
    chk({pfx, ".req_allow"},  DW'(req_allow),  DW'(mq.size() < DEPTH));
    chk({pfx, ".resp_valid"}, DW'(resp_valid), DW'(ev));
    chk({pfx, ".resp_rdata"}, resp_rdata,      ed);
    chk({pfx, ".wr_done"},    DW'(wr_done),    DW'(m_wd));
    chk({pfx, ".err"},        DW'(err),        DW'(m_err));
  endtask

  // Advance the model by one clock edge using the inputs held this cycle
  task automatic model_step();
    bit            pop_now;
    bit            push_now;
    bit            wd_now;
    pop_now  = (mq.size() != 0) && !stall;
    push_now = m_wait && pmem_resp && pmem_read && !model_bypass();
    wd_now   = m_wait && pmem_resp && pmem_write;
    if (pop_now) void'(mq.pop_front());
    if (push_now) begin
      if (mq.size() >= DEPTH) m_err[0] = 1'b1;
      else                    mq.push_back(pmem_rdata);
    end
    if (!m_wait && pmem_resp) m_err[1] = 1'b1;
    if (m_wait) begin
      if (pmem_resp) m_wait = 1'b0;
    end else if (pmem_read || pmem_write) begin
      m_wait = 1'b1;
    end
    m_wd = wd_now;
  endtask

  // One clock: drive, check mid-cycle, step model at the edge
  task automatic cycle(input string tag, input bit r, input bit w, input bit rs,
                       input bit st, input logic [DW-1:0] d);
    pmem_read  = r;
    pmem_write = w;
    pmem_resp  = rs;
    stall      = st;
    pmem_rdata = d;
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    m_wait = 1'b0;
    m_wd   = 1'b0;
    m_err  = 2'b00;
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once
  task automatic mid_reset(input string tag);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_resp  = 1'b0;
    stall      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, ".busy"},       DW'(busy),       '0);
    chk({tag, ".req_allow"},  DW'(req_allow),  DW'(1));
    chk({tag, ".resp_valid"}, DW'(resp_valid), '0);
    chk({tag, ".resp_rdata"}, resp_rdata,      '0);
    chk({tag, ".wr_done"},    DW'(wr_done),    '0);
    chk({tag, ".err"},        DW'(err),        '0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] a5;
    int            op;
    int            held;
    bit            r;
    bit            w;
    bit            rs;
    bit            st;

    a5 = {32{8'hA5}};
    rst_n      = 1'b0;
    stall      = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // Single read, no stall
    cycle("rd_req",  1, 0, 0, 0, '0);
    cycle("rd_resp", 1, 0, 1, 0, a5);
    cycle("rd_out",  0, 0, 0, 0, '0);
    cycle("rd_idle", 0, 0, 0, 0, '0);

    // Write completion pulse
    cycle("wr_req",  0, 1, 0, 0, '0);
    cycle("wr_resp", 0, 1, 1, 0, '0);
    cycle("wr_pls",  0, 0, 0, 0, '0);
    cycle("wr_idle", 0, 0, 0, 0, '0);

    // Three reads under stall: third overflows
    for (int i = 1; i <= 3; i++) begin
      cycle("st_req",  1, 0, 0, 1, '0);
      cycle("st_resp", 1, 0, 1, 1, DW'(i));
    end
    cycle("st_full", 0, 0, 0, 1, '0);
    chk("ovf.req_allow", DW'(req_allow), '0);
    chk("ovf.err",       DW'(err),       DW'(2'b01));
    chk("ovf.head",      resp_rdata,     DW'(1));

    // Full, pop and push in the same cycle
    cycle("fp_req",  1, 0, 0, 1, '0);
    cycle("fp_resp", 1, 0, 1, 0, DW'(4));
    chk("fp.head",   resp_rdata, DW'(2));
    chk("fp.err",    DW'(err),   DW'(2'b01));
    cycle("fp_out2", 0, 0, 0, 0, '0);
    cycle("fp_out4", 0, 0, 0, 0, '0);
    cycle("fp_idle", 0, 0, 0, 0, '0);

    // Spurious response in IDLE
    cycle("spur",    0, 0, 1, 0, rand_line());
    cycle("spur_ck", 0, 0, 0, 0, '0);
    chk("spur.err", DW'(err), DW'(2'b11));

    // Reset in WAIT with a buffered entry, then a late response
    cycle("mr_req",  1, 0, 0, 1, '0);
    cycle("mr_resp", 1, 0, 1, 1, rand_line());
    cycle("mr_req2", 1, 0, 0, 1, '0);
    mid_reset("mid_rst");
    cycle("late",    0, 0, 1, 0, rand_line());
    cycle("late_ck", 0, 0, 0, 0, '0);

    // Randomized traffic
    op   = 0;
    held = 0;
    for (int i = 0; i < 600; i++) begin
      r  = (op == 1);
      w  = (op == 2);
      rs = 1'b0;
      if (op != 0 && held > 0 && $urandom_range(0, 2) == 0) rs = 1'b1;
      else if (op == 0 && $urandom_range(0, 15) == 0)       rs = 1'b1;
      st = ($urandom_range(0, 9) < 4);
      cycle("rnd", r, w, rs, st, rand_line());
      if (op != 0) begin
        if (rs) op = 0;
        else    held++;
      end else if ($urandom_range(0, 2) == 0) begin
        op   = $urandom_range(1, 2);
        held = 0;
      end
      if (i == 300) begin
        mid_reset("rnd_rst");
        op = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pmem_resp_buffer
